// File: rtl/pipeline_ir_chain.sv
// pipeline_ir_chain
//   Instruction/PC register chain between fetch and the per-stage decoders.
//   Moves each fetched instruction through DEC -> EXE -> MEM -> WB with a
//   valid bit per stage. It stalls DEC for one cycle on a load-use hazard and
//   squashes DEC/EXE on a resolved branch (CLEAR) or an accepted interrupt
//   (INT_TAKEN). It also keeps saturating stall and flush counters.
// Ports
//   CLK, RST                 clock (rising edge), async active-high reset
//   IF_IR, IF_PC, IF_VALID   fetched instruction, its PC, real-instruction flag
//   CLEAR, INT_TAKEN         squash DEC and EXE
//   *_IR, *_IR_EN            stage instruction register and valid bit
//   DEC_PC, EXE_PC           PC of the DEC and EXE instructions
//   PC_WRITE                 0 = fetch holds PC/IF_IR this cycle
//   STALL                    load-use stall this cycle (combinational)
//   STALL_CNT, FLUSH_CNT     saturating performance counters
module pipeline_ir_chain #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter bit          HAZARD_EN = 1'b1,
    parameter int          CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      IF_IR,
    input  logic [31:0]      IF_PC,
    input  logic             IF_VALID,
    input  logic             CLEAR,
    input  logic             INT_TAKEN,
    output logic [31:0]      DEC_IR,
    output logic [31:0]      EXE_IR,
    output logic [31:0]      MEM_IR,
    output logic [31:0]      WB_IR,
    output logic             DEC_IR_EN,
    output logic             EXE_IR_EN,
    output logic             MEM_IR_EN,
    output logic             WB_IR_EN,
    output logic [31:0]      DEC_PC,
    output logic [31:0]      EXE_PC,
    output logic             PC_WRITE,
    output logic             STALL,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      dec_ir_q, exe_ir_q, mem_ir_q, wb_ir_q;
    logic [31:0]      dec_ir_d, exe_ir_d, mem_ir_d, wb_ir_d;
    logic             dec_en_q, exe_en_q, mem_en_q, wb_en_q;
    logic             dec_en_d, exe_en_d, mem_en_d, wb_en_d;
    logic [31:0]      dec_pc_q, exe_pc_q, dec_pc_d, exe_pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic flush, hazard, stall;

    function automatic logic uses_rs1(input logic [31:0] ir);
        case (ir[6:0])
            OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: uses_rs1 = 1'b1;
            OPC_SYSTEM: uses_rs1 = ~ir[14];   // CSR immediate forms carry uimm in rs1
            default:    uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ir);
        case (ir[6:0])
            OPC_BRANCH, OPC_STORE, OPC_OP: uses_rs2 = 1'b1;
            default:                       uses_rs2 = 1'b0;
        endcase
    endfunction

    assign flush = CLEAR | INT_TAKEN;

    always_comb begin
        hazard = 1'b0;
        if (HAZARD_EN && exe_en_q && dec_en_q && (exe_ir_q[6:0] == OPC_LOAD) &&
            (exe_ir_q[11:7] != 5'd0)) begin
            hazard = (uses_rs1(dec_ir_q) && (dec_ir_q[19:15] == exe_ir_q[11:7])) ||
                     (uses_rs2(dec_ir_q) && (dec_ir_q[24:20] == exe_ir_q[11:7]));
        end
    end

    // A flush discards the dependent instruction anyway, so it masks the stall
    // and fetch keeps moving to the redirect target.
    assign stall = hazard & ~flush;

    always_comb begin
        // default: normal advance; invalid fetches enter DEC as a bubble
        dec_ir_d    = IF_VALID ? IF_IR : NOP_INSTR;
        dec_en_d    = IF_VALID;
        dec_pc_d    = IF_PC;
        exe_ir_d    = dec_ir_q;
        exe_en_d    = dec_en_q;
        exe_pc_d    = dec_pc_q;
        mem_ir_d    = exe_ir_q;
        mem_en_d    = exe_en_q;
        wb_ir_d     = mem_ir_q;
        wb_en_d     = mem_en_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (flush) begin
            dec_ir_d = NOP_INSTR;
            dec_en_d = 1'b0;
            exe_ir_d = NOP_INSTR;
            exe_en_d = 1'b0;
            if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else if (stall) begin
            dec_ir_d = dec_ir_q;
            dec_en_d = dec_en_q;
            dec_pc_d = dec_pc_q;
            exe_ir_d = NOP_INSTR;
            exe_en_d = 1'b0;
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dec_ir_q    <= NOP_INSTR;
            exe_ir_q    <= NOP_INSTR;
            mem_ir_q    <= NOP_INSTR;
            wb_ir_q     <= NOP_INSTR;
            dec_en_q    <= 1'b0;
            exe_en_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            wb_en_q     <= 1'b0;
            dec_pc_q    <= 32'd0;
            exe_pc_q    <= 32'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            dec_ir_q    <= dec_ir_d;
            exe_ir_q    <= exe_ir_d;
            mem_ir_q    <= mem_ir_d;
            wb_ir_q     <= wb_ir_d;
            dec_en_q    <= dec_en_d;
            exe_en_q    <= exe_en_d;
            mem_en_q    <= mem_en_d;
            wb_en_q     <= wb_en_d;
            dec_pc_q    <= dec_pc_d;
            exe_pc_q    <= exe_pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign DEC_IR    = dec_ir_q;
    assign EXE_IR    = exe_ir_q;
    assign MEM_IR    = mem_ir_q;
    assign WB_IR     = wb_ir_q;
    assign DEC_IR_EN = dec_en_q;
    assign EXE_IR_EN = exe_en_q;
    assign MEM_IR_EN = mem_en_q;
    assign WB_IR_EN  = wb_en_q;
    assign DEC_PC    = dec_pc_q;
    assign EXE_PC    = exe_pc_q;
    assign STALL     = stall;
    assign PC_WRITE  = ~stall | RST;
    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;
endmodule
